// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: DMType width codes, FSM encoding, lane count.
package lsu_pkg;

    localparam int LANES = 4;

    // Width codes as driven by the control unit's DMType field.
    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic dm_is_half(input logic [2:0] dm);
        return (dm == dm_halfword) || (dm == dm_halfword_unsigned);
    endfunction

    function automatic logic dm_is_byte(input logic [2:0] dm);
        return (dm == dm_byte) || (dm == dm_byte_unsigned);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extension, misalignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         dmtype,
    input  logic [LANES*8-1:0] wdata,
    input  logic [LANES*8-1:0] mem_rdata,
    output logic [LANES-1:0]   be,
    output logic [LANES*8-1:0] lane_wdata,
    output logic [LANES*8-1:0] ext_rdata,
    output logic               misalign
);

    logic [LANES*8-1:0] sh;

    assign sh = mem_rdata >> {addr_lo, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = sh;
        misalign   = (addr_lo != 2'b00);
        if (dm_is_byte(dmtype)) begin
            be         = 4'b0001 << addr_lo;
            lane_wdata = {4{wdata[7:0]}};
            misalign   = 1'b0;
            ext_rdata  = (dmtype == dm_byte) ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
        end else if (dm_is_half(dmtype)) begin
            be         = 4'b0011 << addr_lo;
            lane_wdata = {2{wdata[15:0]}};
            misalign   = addr_lo[0];
            ext_rdata  = (dmtype == dm_halfword) ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM between EX and data memory; optional REQ timeout under LSU_TIMEOUT_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_dmtype,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic              resp_buserr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        dmtype_q, dmtype_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              in_req, in_idle;

    logic [1:0]        al_addr_lo;
    logic [2:0]        al_dmtype;
    logic [DATA_W-1:0] al_wdata, al_lane_wdata, al_ext_rdata;
    logic [3:0]        al_be;
    logic              al_misalign;

    assign in_req  = (state_q == ST_REQ);
    assign in_idle = (state_q == ST_IDLE);

    // In IDLE the aligner looks at the incoming op (misalign decision); otherwise at the latch.
    assign al_addr_lo = in_idle ? req_addr[1:0] : addr_q[1:0];
    assign al_dmtype  = in_idle ? req_dmtype    : dmtype_q;
    assign al_wdata   = in_idle ? req_wdata     : wdata_q;

    lsu_align u_align (
        .addr_lo    (al_addr_lo),
        .dmtype     (al_dmtype),
        .wdata      (al_wdata),
        .mem_rdata  (mem_rdata),
        .be         (al_be),
        .lane_wdata (al_lane_wdata),
        .ext_rdata  (al_ext_rdata),
        .misalign   (al_misalign)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buserr_q, buserr_d;
    logic             timeout;

    assign timeout     = in_req && !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign cnt_d       = (in_req && !mem_ack) ? cnt_q + 1'b1 : '0;
    assign resp_buserr = buserr_q;
`else
    logic timeout;

    assign timeout     = 1'b0;
    assign resp_buserr = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dmtype_d   = dmtype_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
`ifdef LSU_TIMEOUT_EN
        buserr_d   = buserr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    dmtype_d   = req_dmtype;
                    we_d       = req_we;
                    rdata_d    = '0;
                    misalign_d = al_misalign;
`ifdef LSU_TIMEOUT_EN
                    buserr_d   = 1'b0;
`endif
                    state_d    = al_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : al_ext_rdata;
                    state_d = ST_DONE;
                end else if (timeout) begin
`ifdef LSU_TIMEOUT_EN
                    buserr_d = 1'b1;
`endif
                    rdata_d  = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            dmtype_q   <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            buserr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dmtype_q   <= dmtype_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            buserr_q   <= buserr_d;
`endif
        end
    end

    assign req_ready     = in_idle;
    assign resp_valid    = (state_q == ST_DONE);
    assign resp_rdata    = rdata_q;
    assign resp_misalign = misalign_q;

    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = in_req ? al_be : 4'b0000;
    assign mem_wdata = in_req ? al_lane_wdata : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan cases plus randomized ops against a size-based model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misalign, resp_buserr;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_buserr(resp_buserr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes; codes 0..4 follow the DMType table, others act as word.
    function automatic int acc_size(input logic [2:0] dm);
        case (dm)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic logic is_signed_ld(input logic [2:0] dm);
        return (dm == 3'd1) || (dm == 3'd3) || (acc_size(dm) == 4);
    endfunction

    function automatic logic m_misalign(input logic [2:0] dm, input logic [31:0] a);
        return (a % acc_size(dm)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] dm, input logic [31:0] a);
        int s = acc_size(dm);
        int o = a % 4;
        int v = ((1 << s) - 1) << o;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] dm, input logic [31:0] wd);
        logic [31:0] r;
        int s = acc_size(dm);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] dm, input logic [31:0] a,
                                            input logic [31:0] md);
        longint s = acc_size(dm);
        longint half = 64'd1 << (8*s - 1);
        longint v = (longint'(md) >> (8 * (a % 4))) & ((half << 1) - 1);
        if (is_signed_ld(dm) && s < 4 && v >= half) v = v - (half << 1);
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic we, input logic [2:0] dm, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] md, input int waits);
        logic        mis  = m_misalign(dm, addr);
        logic [31:0] erd  = (we || mis) ? 32'h0 : m_rdata(dm, addr, md);
        chk("ready_before", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_dmtype = dm; req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wdata = $urandom;
        req_dmtype = 3'($urandom);
        if (mis) begin
            chk("mis_no_mem", mem_req, 1'b0);
            chk("mis_resp_valid", resp_valid, 1'b1);
            chk("mis_flag", resp_misalign, 1'b1);
            chk("mis_rdata", resp_rdata, 32'h0);
        end else begin
            for (int k = 0; k <= waits; k++) begin
                chk("mem_req", mem_req, 1'b1);
                chk("ready_busy", req_ready, 1'b0);
                chk("no_early_resp", resp_valid, 1'b0);
                chk("mem_we", mem_we, we);
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_be", mem_be, m_be(dm, addr));
                chk("mem_wdata", mem_wdata, m_wdata(dm, wd));
                mem_ack   = (k == waits);
                mem_rdata = (k == waits) ? md : $urandom;
                tick();
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk("resp_valid", resp_valid, 1'b1);
            chk("resp_misalign", resp_misalign, 1'b0);
            chk("resp_rdata", resp_rdata, erd);
            chk("mem_req_drop", mem_req, 1'b0);
        end
        chk("resp_buserr", resp_buserr, 1'b0);
        last_rdata = resp_rdata;
        tick();
        chk("resp_pulse_end", resp_valid, 1'b0);
        chk("rdata_hold", resp_rdata, erd);
        chk("mem_be_idle", mem_be, 4'b0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'd0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        tick();

        // Directed plan cases
        run_op(1'b1, 3'd3, 32'h0000_1003, 32'h0000_00A5, 32'h1234_5678, 0);
        chk("plan_store_rdata", last_rdata, 32'h0);
        run_op(1'b0, 3'd3, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        chk("plan_lb", last_rdata, 32'hFFFF_FFFF);
        run_op(1'b0, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 0);
        chk("plan_lbu", last_rdata, 32'h0000_0080);
        run_op(1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        chk("plan_lh", last_rdata, 32'hFFFF_80FF);
        run_op(1'b0, 3'd0, 32'h0000_3002, 32'h0, 32'h0, 0);
        run_op(1'b0, 3'd1, 32'h0000_3001, 32'h0, 32'h0, 0);
        run_op(1'b0, 3'd0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 5);
        chk("plan_wait_word", last_rdata, 32'hCAFE_F00D);

        // Randomized ops, including unknown dmtype codes
        for (int n = 0; n < 60; n++) begin
            run_op(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        // Reset during a wait, then a stray ack
        req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'd0; req_addr = 32'h0000_5000;
        tick();
        req_valid = 1'b0;
        chk("rstmid_in_req", mem_req, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_mem_req", mem_req, 1'b0);
        chk("rstmid_ready", req_ready, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_no_resp", resp_valid, 1'b0);
        chk("stray_ack_no_req", mem_req, 1'b0);
        tick();
        chk("stray_ack_no_resp2", resp_valid, 1'b0);
        chk("stray_ack_ready", req_ready, 1'b1);

        // No-ack behaviour: timeout with the macro, indefinite wait without it
        req_valid = 1'b1; req_we = 1'b0; req_dmtype = 3'd0; req_addr = 32'h0000_6000;
        tick();
        req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("to_mem_req", mem_req, 1'b1);
            tick();
        end
        chk("to_mem_req_drop", mem_req, 1'b0);
        chk("to_resp_valid", resp_valid, 1'b1);
        chk("to_buserr", resp_buserr, 1'b1);
        chk("to_rdata", resp_rdata, 32'h0);
        tick();
        chk("to_ready", req_ready, 1'b1);
`else
        for (int k = 0; k < 12; k++) begin
            chk("wait_mem_req", mem_req, 1'b1);
            chk("wait_no_resp", resp_valid, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wait_rst_ready", req_ready, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
